// File: rtl/otter_mc_ctrl.sv
// Multicycle control unit for the OTTER RV32I core.
// Walks FETCH -> DECODE -> EXEC (-> MEM (-> WB)) and stops in HALT on an unsupported instruction.
// Outputs are decoded combinationally from the state register, ir, the branch flags and
// mem_ack, and are forced to their idle values while rst is high.
module otter_mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir,
  input  logic        br_eq,
  input  logic        br_lt,
  input  logic        br_ltu,
  input  logic        mem_ack,
  output logic        mem_rden1,
  output logic        ir_write,
  output logic [3:0]  alu_fun,
  output logic [1:0]  srcA_sel,
  output logic [1:0]  srcB_sel,
  output logic        pc_write,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  rf_wr_sel,
  output logic        mem_rden2,
  output logic        mem_we2,
  output logic        illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_LUI = 4'b1001;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  state_t state, next_state;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_store;
  logic       taken;
  logic       br_legal;
  logic       unused_ir;

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign is_store  = (opcode == OPC_STORE);
  assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

  // Branch condition decode; funct3 010/011 are not branches
  always_comb begin
    taken    = 1'b0;
    br_legal = 1'b1;
    case (funct3)
      3'b000:  taken = br_eq;
      3'b001:  taken = ~br_eq;
      3'b100:  taken = br_lt;
      3'b101:  taken = ~br_lt;
      3'b110:  taken = br_ltu;
      3'b111:  taken = ~br_ltu;
      default: br_legal = 1'b0;
    endcase
  end

  // State register; reset lands in FETCH at once, dropping any memory request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FETCH;
    else     state <= next_state;
  end

  // Next-state and output decode
  always_comb begin
    next_state = state;
    mem_rden1  = 1'b0;
    ir_write   = 1'b0;
    alu_fun    = ALU_ADD;
    srcA_sel   = 2'd0;
    srcB_sel   = 2'd0;
    pc_write   = 1'b0;
    pc_sel     = 2'd0;
    rf_we      = 1'b0;
    rf_wr_sel  = 2'd0;
    mem_rden2  = 1'b0;
    mem_we2    = 1'b0;
    illegal    = 1'b0;

    case (state)
      ST_FETCH: begin
        mem_rden1  = 1'b1;
        next_state = ST_DECODE;
      end
      ST_DECODE: begin
        ir_write   = 1'b1;
        next_state = ST_EXEC;
      end
      ST_EXEC: begin
        next_state = ST_FETCH;
        case (opcode)
          OPC_OP: begin
            alu_fun   = {ir[30], funct3};
            rf_we     = 1'b1;
            rf_wr_sel = 2'd2;
            pc_write  = 1'b1;
          end
          OPC_OP_IMM: begin
            alu_fun   = {(funct3 == 3'b101) ? ir[30] : 1'b0, funct3};
            srcB_sel  = 2'd1;
            rf_we     = 1'b1;
            rf_wr_sel = 2'd2;
            pc_write  = 1'b1;
          end
          OPC_LUI: begin
            alu_fun   = ALU_LUI;
            srcA_sel  = 2'd1;
            rf_we     = 1'b1;
            rf_wr_sel = 2'd2;
            pc_write  = 1'b1;
          end
          OPC_AUIPC: begin
            srcA_sel  = 2'd2;
            srcB_sel  = 2'd3;
            rf_we     = 1'b1;
            rf_wr_sel = 2'd2;
            pc_write  = 1'b1;
          end
          OPC_JAL: begin
            pc_sel    = 2'd3;
            rf_we     = 1'b1;
            pc_write  = 1'b1;
          end
          OPC_JALR: begin
            pc_sel    = 2'd1;
            rf_we     = 1'b1;
            pc_write  = 1'b1;
          end
          OPC_BRANCH: begin
            if (br_legal) begin
              pc_write = 1'b1;
              pc_sel   = taken ? 2'd2 : 2'd0;
            end else begin
              next_state = ST_HALT;
            end
          end
          OPC_LOAD: begin
            srcB_sel   = 2'd1;
            next_state = ST_MEM;
          end
          OPC_STORE: begin
            srcB_sel   = 2'd2;
            next_state = ST_MEM;
          end
          default: next_state = ST_HALT;
        endcase
      end
      ST_MEM: begin
        // Hold the request and the address selects until the memory acknowledges
        srcB_sel  = is_store ? 2'd2 : 2'd1;
        mem_we2   = is_store;
        mem_rden2 = ~is_store;
        if (mem_ack) begin
          if (is_store) begin
            pc_write   = 1'b1;
            next_state = ST_FETCH;
          end else begin
            next_state = ST_WB;
          end
        end
      end
      ST_WB: begin
        rf_we      = 1'b1;
        rf_wr_sel  = 2'd1;
        pc_write   = 1'b1;
        next_state = ST_FETCH;
      end
      ST_HALT: begin
        illegal = 1'b1;
      end
      default: next_state = ST_FETCH;
    endcase

    // Reset overrides every output immediately
    if (rst) begin
      mem_rden1 = 1'b0;
      ir_write  = 1'b0;
      alu_fun   = ALU_ADD;
      srcA_sel  = 2'd0;
      srcB_sel  = 2'd0;
      pc_write  = 1'b0;
      pc_sel    = 2'd0;
      rf_we     = 1'b0;
      rf_wr_sel = 2'd0;
      mem_rden2 = 1'b0;
      mem_we2   = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_otter_mc_ctrl.sv
// Scoreboard bench for otter_mc_ctrl: the driver queues the expected output word for every
// cycle it drives, and a negedge monitor pops and compares it against the DUT outputs.
module tb_otter_mc_ctrl;

  typedef struct packed {
    logic       mem_rden1;
    logic       ir_write;
    logic [3:0] alu_fun;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [1:0] rf_wr_sel;
    logic       mem_rden2;
    logic       mem_we2;
    logic       illegal;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] ir;
  logic        br_eq, br_lt, br_ltu;
  logic        mem_ack;
  logic        mem_rden1, ir_write, pc_write, rf_we, mem_rden2, mem_we2, illegal;
  logic [3:0]  alu_fun;
  logic [1:0]  srcA_sel, srcB_sel, pc_sel, rf_wr_sel;

  otter_mc_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .ir       (ir),
    .br_eq    (br_eq),
    .br_lt    (br_lt),
    .br_ltu   (br_ltu),
    .mem_ack  (mem_ack),
    .mem_rden1(mem_rden1),
    .ir_write (ir_write),
    .alu_fun  (alu_fun),
    .srcA_sel (srcA_sel),
    .srcB_sel (srcB_sel),
    .pc_write (pc_write),
    .pc_sel   (pc_sel),
    .rf_we    (rf_we),
    .rf_wr_sel(rf_wr_sel),
    .mem_rden2(mem_rden2),
    .mem_we2  (mem_we2),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  // Monitor: one expected word per cycle, compared mid-cycle
  always @(negedge clk) begin
    exp_t  e;
    exp_t  a;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a.mem_rden1 = mem_rden1;
      a.ir_write  = ir_write;
      a.alu_fun   = alu_fun;
      a.src_a     = srcA_sel;
      a.src_b     = srcB_sel;
      a.pc_write  = pc_write;
      a.pc_sel    = pc_sel;
      a.rf_we     = rf_we;
      a.rf_wr_sel = rf_wr_sel;
      a.mem_rden2 = mem_rden2;
      a.mem_we2   = mem_we2;
      a.illegal   = illegal;
      n_vec = n_vec + 1;
      if (a !== e) begin
        n_bad = n_bad + 1;
        $display("FAIL %s: got %05h want %05h (t=%0t)", nm, a, e, $time);
      end
    end
  end

  function automatic exp_t f_e();
    exp_t e = '0;
    e.mem_rden1 = 1'b1;
    return e;
  endfunction

  function automatic exp_t d_e();
    exp_t e = '0;
    e.ir_write = 1'b1;
    return e;
  endfunction

  function automatic exp_t h_e();
    exp_t e = '0;
    e.illegal = 1'b1;
    return e;
  endfunction

  function automatic exp_t ex(input logic [3:0] af, input logic [1:0] sa, input logic [1:0] sb,
                              input logic pw, input logic [1:0] ps, input logic we,
                              input logic [1:0] ws);
    exp_t e = '0;
    e.alu_fun   = af;
    e.src_a     = sa;
    e.src_b     = sb;
    e.pc_write  = pw;
    e.pc_sel    = ps;
    e.rf_we     = we;
    e.rf_wr_sel = ws;
    return e;
  endfunction

  function automatic exp_t mem_e(input logic st, input logic pw);
    exp_t e = '0;
    e.src_b     = st ? 2'd2 : 2'd1;
    e.mem_we2   = st;
    e.mem_rden2 = ~st;
    e.pc_write  = pw;
    return e;
  endfunction

  // Queue the expectation for the current cycle, then move past the next rising edge
  task automatic cyc(input string nm, input exp_t e);
    name_q.push_back(nm);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run3(input string nm, input logic [31:0] irv, input exp_t ee);
    ir = irv;
    cyc({nm, "/fetch"}, f_e());
    cyc({nm, "/decode"}, d_e());
    cyc({nm, "/exec"}, ee);
  endtask

  initial begin
    rst = 1'b1; ir = 32'h0; br_eq = 1'b0; br_lt = 1'b0; br_ltu = 1'b0; mem_ack = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset0", '0);
    mem_ack = 1'b1;
    cyc("reset1_ack", '0);
    rst = 1'b0;
    mem_ack = 1'b0;

    run3("sub",   32'h40208133, ex(4'b1000, 2'd0, 2'd0, 1'b1, 2'd0, 1'b1, 2'd2));
    run3("srai",  32'h4020D093, ex(4'b1101, 2'd0, 2'd1, 1'b1, 2'd0, 1'b1, 2'd2));
    run3("srli",  32'h0020D093, ex(4'b0101, 2'd0, 2'd1, 1'b1, 2'd0, 1'b1, 2'd2));
    run3("addi30",32'h40008093, ex(4'b0000, 2'd0, 2'd1, 1'b1, 2'd0, 1'b1, 2'd2));
    run3("lui",   32'h000010B7, ex(4'b1001, 2'd1, 2'd0, 1'b1, 2'd0, 1'b1, 2'd2));
    run3("auipc", 32'h00001097, ex(4'b0000, 2'd2, 2'd3, 1'b1, 2'd0, 1'b1, 2'd2));
    run3("jal",   32'h0080006F, ex(4'b0000, 2'd0, 2'd0, 1'b1, 2'd3, 1'b1, 2'd0));
    run3("jalr",  32'h000080E7, ex(4'b0000, 2'd0, 2'd0, 1'b1, 2'd1, 1'b1, 2'd0));

    br_lt = 1'b1;
    run3("blt_t", 32'h0020C463, ex(4'b0000, 2'd0, 2'd0, 1'b1, 2'd2, 1'b0, 2'd0));
    br_lt = 1'b0;
    run3("blt_n", 32'h0020C463, ex(4'b0000, 2'd0, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0));
    br_ltu = 1'b1;
    run3("bgeu_n",32'h0020F463, ex(4'b0000, 2'd0, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0));
    br_ltu = 1'b0;
    br_eq = 1'b0;
    run3("bne_t", 32'h00209463, ex(4'b0000, 2'd0, 2'd0, 1'b1, 2'd2, 1'b0, 2'd0));

    // Load, ack ignored before MEM, three MEM cycles: F D E M M M W = 7
    ir = 32'h0000A083;
    mem_ack = 1'b1;
    cyc("lw/fetch", f_e());
    cyc("lw/decode", d_e());
    mem_ack = 1'b0;
    cyc("lw/exec", ex(4'b0000, 2'd0, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0));
    cyc("lw/mem1", mem_e(1'b0, 1'b0));
    cyc("lw/mem2", mem_e(1'b0, 1'b0));
    mem_ack = 1'b1;
    cyc("lw/mem3", mem_e(1'b0, 1'b0));
    mem_ack = 1'b0;
    cyc("lw/wb", ex(4'b0000, 2'd0, 2'd0, 1'b1, 2'd0, 1'b1, 2'd1));

    // Store with one wait cycle
    run3("sw", 32'h0020A023, ex(4'b0000, 2'd0, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0));
    cyc("sw/mem1", mem_e(1'b1, 1'b0));
    mem_ack = 1'b1;
    cyc("sw/mem2", mem_e(1'b1, 1'b1));
    mem_ack = 1'b0;

    // Reset while a store waits in MEM: request and pc_write drop at once
    run3("sw_rst", 32'h0020A023, ex(4'b0000, 2'd0, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0));
    cyc("sw_rst/mem1", mem_e(1'b1, 1'b0));
    rst = 1'b1;
    mem_ack = 1'b1;
    cyc("sw_rst/mid_mem", '0);
    rst = 1'b0;
    mem_ack = 1'b0;
    run3("post_rst_add", 32'h40208133, ex(4'b1000, 2'd0, 2'd0, 1'b1, 2'd0, 1'b1, 2'd2));

    // Reserved branch funct3 halts with no writes
    run3("br010", 32'h0020A463, '0);
    cyc("br010/halt", h_e());
    rst = 1'b1;
    cyc("br010/rst", '0);
    rst = 1'b0;

    // Unlisted opcode: HALT holds through mem_ack activity until reset
    run3("ill7f", 32'h0000007F, '0);
    for (int i = 0; i < 12; i++) begin
      mem_ack = i[0];
      cyc("ill7f/halt", h_e());
    end
    rst = 1'b1;
    cyc("ill7f/rst", '0);
    rst = 1'b0;
    mem_ack = 1'b0;
    cyc("ill7f/fetch", f_e());
    cyc("ill7f/decode", d_e());

    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
